fp_unit: RTL and testbench
==========================

# fp_unit

Multi-cycle IEEE-754 single-precision floating-point unit for the RISC-V processor's floating-point path. It accepts two 32-bit operands and a 2-bit opcode on a start pulse, then computes add, subtract, multiply or less-than compare. It returns the 32-bit result with a one-cycle done pulse. One operation is in flight at a time.

## Interface
- No parameters.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- a  input  32  operand A, IEEE-754 binary32.
- b  input  32  operand B, IEEE-754 binary32.
- opcode  input  2  operation select: 00 add (a+b), 01 sub (a−b), 10 mul (a·b), 11 flt (a<b).
- start  input  1  request; sampled only in IDLE.
- s  output  32  result; holds its value until the next done.
- done  output  1  one-cycle pulse marking s valid.

## Operation
- Reset values: s = 0x00000000, done = 0, state = IDLE, all operand registers cleared.
- FSM states: IDLE → UNPACK → EXEC → NORM → ROUND → IDLE.
- IDLE: on start=1, latch a, b and opcode, then go to UNPACK. When start=0, stay in IDLE.
- UNPACK:
  - Split each operand into sign, 8-bit exponent and 24-bit significand with the hidden 1.
  - Denormal inputs are flushed to ±0.
  - Classify each operand as zero, inf or NaN.
- EXEC, add/sub:
  - For sub, invert b's sign.
  - Align the smaller-exponent significand by a right shift of the exponent difference. Keep 3 extra bits (guard, round, sticky); sticky is the OR of all shifted-out bits.
  - Add magnitudes if the signs match; otherwise subtract the smaller from the larger. The result sign is the sign of the larger magnitude.
  - An exact-zero result is +0.
- EXEC, mul:
  - Sign = sa XOR sb.
  - Exponent = ea + eb − 127, computed in 10 bits signed.
  - 48-bit significand product.
- EXEC, flt:
  - Result is 0x00000001 when a<b numerically, else 0x00000000.
  - +0 and −0 compare equal.
  - Any NaN operand gives 0.
  - flt passes straight through NORM and ROUND unchanged.
- NORM:
  - Shift left by the leading-zero count, or right by one on carry-out.
  - Adjust the exponent to match and preserve sticky.
- ROUND:
  - Round to nearest, ties to even.
  - A mantissa overflow from rounding increments the exponent.
- Special cases for add/sub/mul:
  - Any NaN input → 0x7FC00000.
  - inf − inf → 0x7FC00000.
  - 0 · inf → 0x7FC00000.
  - inf operand otherwise → correctly signed inf.
  - Exponent ≥ 255 after rounding → signed inf (0x7F800000 or 0xFF800000).
  - Exponent ≤ 0 → signed zero.
- done is driven high in the cycle s is updated; it is not sticky.

## Timing
- Fixed latency. start is sampled high at rising edge k; s is updated and done=1 after edge k+4. done returns to 0 after edge k+5.
- start is ignored while not in IDLE; changes on a, b and opcode during that time have no effect.
- start held high continuously: a new operation is accepted in the cycle after done, i.e. back-to-back throughput is one result per 5 cycles.
- rst asserted mid-operation: at the next edge the FSM returns to IDLE, done=0, s=0, and the pending result is discarded.
- rst and start high in the same cycle: reset wins.

## Structure
- A shared package fp_pkg holds:
  - the opcode constants OP_ADD, OP_SUB, OP_MUL, OP_FLT;
  - the FSM state enumeration;
  - the field-width constants EXP_W=8, MAN_W=23, BIAS=127;
  - the canonical constants QNAN=0x7FC00000 and PINF=0x7F800000.
- One sub-module, fp_lzc: a combinational 28-bit leading-zero counter used by NORM.
- Everything else lives in fp_unit.

## Test plan
- a=0x42780000 (62.0), b=0x43790000 (249.0), opcode=10 → done pulses 5 cycles after start, s=0x46713800 (15438.0).
- Same operands, opcode=00 → s=0x439B8000 (311.0). Same operands, opcode=01 → s=0xC33B0000 (−187.0).
- Same operands, opcode=11 → s=0x00000001. Swap a and b → s=0x00000000.
- a=0x7F800000, b=0xFF800000, opcode=00 → s=0x7FC00000. a=0x7F000000, b=0x40000000, opcode=10 → s=0x7F800000 (overflow).
- Assert rst two cycles after start → no done pulse, s=0. Then start with a=0x3F800000, b=0x3F800000, opcode=00 → s=0x40000000, with new a/b values driven mid-operation ignored.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the single-precision floating-point unit:
// opcodes, FSM states, field widths, canonical constants and operand unpacking.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_FLT = 2'b11;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_EXEC,
    S_NORM,
    S_ROUND
  } state_t;

  // One operand split into fields, with its special-value class.
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   sig;
    logic             isZero;
    logic             isInf;
    logic             isNan;
  } operand_t;

  // Splits a binary32 word into fields; denormals and zeros become a clean
  // zero (exponent 0, significand 0) so the datapath never sees a hidden-0 value.
  function automatic operand_t unpackOperand(input logic [31:0] value, input logic flipSign);
    operand_t o;
    o.sign   = value[31] ^ flipSign;
    o.exp    = value[30:23];
    o.sig    = {1'b1, value[22:0]};
    o.isZero = (value[30:23] == 8'h00);
    o.isInf  = (value[30:23] == 8'hFF) && (value[22:0] == 23'd0);
    o.isNan  = (value[30:23] == 8'hFF) && (value[22:0] != 23'd0);
    if (o.isZero) begin
      o.exp = '0;
      o.sig = '0;
    end
    return o;
  endfunction

endpackage

// File: rtl/fp_if.sv
// Operand/result bundle between the processor floating-point path and fp_unit.
interface fp_if;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  opcode;
  logic        start;
  logic [31:0] s;
  logic        done;

  modport master (output a, b, opcode, start, input s, done);
  modport slave  (input a, b, opcode, start, output s, done);
endinterface

// File: rtl/fp_lzc.sv
// Combinational 28-bit leading-zero counter used to normalise the working significand.
module fp_lzc (
  input  logic [27:0] i_value,
  output logic [4:0]  o_count
);

  // Scan from LSB upward so the highest set bit makes the final assignment.
  always_comb begin
    o_count = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (i_value[i]) o_count = 5'(27 - i);
    end
  end

endmodule

// File: rtl/fp_unit.sv
// Multi-cycle IEEE-754 binary32 add/sub/mul/less-than unit, one operation in flight.
// Working significand layout: bit 27 carry, bit 26 hidden one, bits 25:3 mantissa,
// bits 2:0 guard/round/sticky.
module fp_unit
  import fp_pkg::*;
(
  input  logic clk,
  input  logic rst,
  fp_if.slave  bus
);

  state_t             r_state;
  state_t             w_nextState;
  logic               w_latch;
  logic               w_finish;

  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic [1:0]         r_op;
  operand_t           r_ua;
  operand_t           r_ub;

  logic               r_special;
  logic [31:0]        r_specialVal;
  logic               r_sign;
  logic signed [9:0]  r_exp;
  logic [27:0]        r_mag;

  logic [31:0]        r_s;
  logic               r_done;

  operand_t           w_large;
  operand_t           w_small;
  logic [7:0]         w_expDiff;
  logic [49:0]        w_alignExt;
  logic [26:0]        w_smallAl;
  logic [27:0]        w_addMag;
  logic [47:0]        w_prod;
  logic [27:0]        w_mulMag;
  logic signed [9:0]  w_mulExp;
  logic               w_less;
  logic               w_special;
  logic [31:0]        w_specialVal;

  logic [4:0]         w_lzc;
  logic [4:0]         w_shift;
  logic [27:0]        w_normMag;
  logic signed [9:0]  w_normExp;

  logic               w_roundUp;
  logic [23:0]        w_rounded;
  logic signed [9:0]  w_roundExp;
  logic [31:0]        w_result;

  fp_lzc u_lzc (
    .i_value (r_mag),
    .o_count (w_lzc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nextState;
  end

  // Fixed five-step sequence; only IDLE looks at start.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:   if (bus.start) w_nextState = S_UNPACK;
      S_UNPACK: w_nextState = S_EXEC;
      S_EXEC:   w_nextState = S_NORM;
      S_NORM:   w_nextState = S_ROUND;
      S_ROUND:  w_nextState = S_IDLE;
      default:  w_nextState = S_IDLE;
    endcase
  end

  // FSM outputs: operand capture in IDLE and result publication leaving ROUND.
  always_comb begin
    w_latch  = (r_state == S_IDLE) && bus.start;
    w_finish = (r_state == S_ROUND);
  end

  // Add/sub alignment: the smaller magnitude is shifted right, shifted-out bits fold into sticky.
  always_comb begin
    if ({r_ua.exp, r_ua.sig} >= {r_ub.exp, r_ub.sig}) begin
      w_large = r_ua;
      w_small = r_ub;
    end else begin
      w_large = r_ub;
      w_small = r_ua;
    end
    w_expDiff  = w_large.exp - w_small.exp;
    w_alignExt = {w_small.sig, 26'd0} >> w_expDiff;
    if (w_expDiff > 8'd26) w_smallAl = {26'd0, |w_small.sig};
    else                   w_smallAl = {w_alignExt[49:24], w_alignExt[23] | (|w_alignExt[22:0])};
    if (w_large.sign == w_small.sign) w_addMag = {1'b0, w_large.sig, 3'b000} + {1'b0, w_smallAl};
    else                              w_addMag = {1'b0, w_large.sig, 3'b000} - {1'b0, w_smallAl};
  end

  // Multiply: full product squeezed into the working layout with sticky from the low bits.
  always_comb begin
    w_prod   = r_ua.sig * r_ub.sig;
    w_mulMag = {w_prod[47:21], w_prod[20] | (|w_prod[19:0])};
    w_mulExp = $signed({2'b00, r_ua.exp}) + $signed({2'b00, r_ub.exp}) - 10'sd127;
  end

  // Compare and special-value resolution; a special result bypasses normalise and round.
  always_comb begin
    w_less = 1'b0;
    if (r_ua.isNan || r_ub.isNan)        w_less = 1'b0;
    else if (r_ua.isZero && r_ub.isZero) w_less = 1'b0;
    else if (r_ua.sign != r_ub.sign)     w_less = r_ua.sign;
    else if (!r_ua.sign)                 w_less = {r_ua.exp, r_ua.sig[22:0]} < {r_ub.exp, r_ub.sig[22:0]};
    else                                 w_less = {r_ua.exp, r_ua.sig[22:0]} > {r_ub.exp, r_ub.sig[22:0]};

    w_special    = 1'b0;
    w_specialVal = 32'd0;
    case (r_op)
      OP_FLT: begin
        w_special    = 1'b1;
        w_specialVal = {31'd0, w_less};
      end
      OP_MUL: begin
        w_special = 1'b1;
        if (r_ua.isNan || r_ub.isNan)                                       w_specialVal = QNAN;
        else if ((r_ua.isZero && r_ub.isInf) || (r_ua.isInf && r_ub.isZero)) w_specialVal = QNAN;
        else if (r_ua.isInf || r_ub.isInf)                                  w_specialVal = {r_ua.sign ^ r_ub.sign, PINF[30:0]};
        else if (r_ua.isZero || r_ub.isZero)                                w_specialVal = {r_ua.sign ^ r_ub.sign, 31'd0};
        else                                                                w_special = 1'b0;
      end
      default: begin
        w_special = 1'b1;
        if (r_ua.isNan || r_ub.isNan)                                 w_specialVal = QNAN;
        else if (r_ua.isInf && r_ub.isInf && (r_ua.sign != r_ub.sign)) w_specialVal = QNAN;
        else if (r_ua.isInf)                                          w_specialVal = {r_ua.sign, PINF[30:0]};
        else if (r_ub.isInf)                                          w_specialVal = {r_ub.sign, PINF[30:0]};
        else if (w_addMag == 28'd0)                                   w_specialVal = 32'd0;
        else                                                          w_special = 1'b0;
      end
    endcase
  end

  // Normalise: one step right on carry-out, otherwise left until the hidden bit is set.
  always_comb begin
    w_shift = 5'd0;
    if (r_mag[27]) begin
      w_normMag = {1'b0, r_mag[27:2], r_mag[1] | r_mag[0]};
      w_normExp = r_exp + 10'sd1;
    end else begin
      w_shift   = w_lzc - 5'd1;
      w_normMag = r_mag << w_shift;
      w_normExp = r_exp - $signed({5'd0, w_shift});
    end
  end

  // Round to nearest even, then clamp to infinity or flush to signed zero.
  always_comb begin
    w_roundUp  = r_mag[2] & (r_mag[1] | r_mag[0] | r_mag[3]);
    w_rounded  = {1'b0, r_mag[25:3]} + {23'd0, w_roundUp};
    w_roundExp = r_exp + $signed({9'd0, w_rounded[23]});
    if (r_special)                  w_result = r_specialVal;
    else if (w_roundExp >= 10'sd255) w_result = {r_sign, PINF[30:0]};
    else if (w_roundExp <= 10'sd0)   w_result = {r_sign, 31'd0};
    else                             w_result = {r_sign, w_roundExp[7:0], w_rounded[22:0]};
  end

  // Datapath registers advance one stage per state; reset discards any pending work.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_ua         <= '0;
      r_ub         <= '0;
      r_special    <= 1'b0;
      r_specialVal <= '0;
      r_sign       <= 1'b0;
      r_exp        <= '0;
      r_mag        <= '0;
      r_s          <= '0;
      r_done       <= 1'b0;
    end else begin
      if (w_latch) begin
        r_a  <= bus.a;
        r_b  <= bus.b;
        r_op <= bus.opcode;
      end
      case (r_state)
        S_UNPACK: begin
          r_ua <= unpackOperand(r_a, 1'b0);
          r_ub <= unpackOperand(r_b, r_op == OP_SUB);
        end
        S_EXEC: begin
          r_special    <= w_special;
          r_specialVal <= w_specialVal;
          if (r_op == OP_MUL) begin
            r_sign <= r_ua.sign ^ r_ub.sign;
            r_exp  <= w_mulExp;
            r_mag  <= w_mulMag;
          end else begin
            r_sign <= w_large.sign;
            r_exp  <= $signed({2'b00, w_large.exp});
            r_mag  <= w_addMag;
          end
        end
        S_NORM: begin
          r_mag <= w_normMag;
          r_exp <= w_normExp;
        end
        default: ;
      endcase
      r_done <= w_finish;
      if (w_finish) r_s <= w_result;
    end
  end

  assign bus.s    = r_s;
  assign bus.done = r_done;

endmodule

// File: tb/tb_fp_unit.sv
// Self-checking bench for fp_unit: directed cases, reset behaviour, back-to-back
// throughput and randomized operands against a real-arithmetic reference model.
module tb_fp_unit;
  import fp_pkg::*;

  logic clk;
  logic rst;
  int   checkCount;
  int   errorCount;

  fp_if bus ();

  fp_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value with its expected value and tallies the outcome.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
    checkCount++;
    if (got !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %08h, expected %08h", tag, got, expected);
    end
  endtask

  // binary32 -> real, with denormals flushed to signed zero.
  function automatic real toReal(input logic [31:0] v);
    logic [63:0] d;
    logic [10:0] ed;
    ed = {3'b000, v[30:23]} + 11'd896;
    if (v[30:23] == 8'h00)      d = {v[31], 63'd0};
    else if (v[30:23] == 8'hFF) d = {v[31], 11'h7FF, v[22:0], 29'd0};
    else                        d = {v[31], ed, v[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // real -> binary32: round to nearest even on 24 bits, then overflow to inf or flush to zero.
  function automatic logic [31:0] fromReal(input real r);
    logic [63:0] d;
    logic [52:0] full;
    logic [24:0] keep;
    logic [28:0] rem;
    int          e;
    d = $realtobits(r);
    e = int'(d[62:52]);
    if (e == 0) return {d[63], 31'd0};
    if (e == 2047) return (d[51:0] != 52'd0) ? QNAN : {d[63], 8'hFF, 23'd0};
    full = {1'b1, d[51:0]};
    keep = {1'b0, full[52:29]};
    rem  = full[28:0];
    if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && keep[0])) keep = keep + 25'd1;
    if (keep[24]) begin
      keep = keep >> 1;
      e = e + 1;
    end
    e = e - 1023 + 127;
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    if (e <= 0) return {d[63], 31'd0};
    return {d[63], e[7:0], keep[22:0]};
  endfunction

  // Reference result for one operation.
  function automatic logic [31:0] modelFp(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    real ra;
    real rb;
    real r;
    ra = toReal(a);
    rb = toReal(b);
    case (op)
      2'b00:   r = ra + rb;
      2'b01:   r = ra - rb;
      2'b10:   r = ra * rb;
      default: return (ra < rb) ? 32'd1 : 32'd0;
    endcase
    if (op != 2'b10 && r == 0.0) return 32'd0;
    return fromReal(r);
  endfunction

  // Random operand biased toward normal values, with specials and range extremes mixed in.
  function automatic logic [31:0] randOperand();
    int sel;
    sel = $urandom_range(0, 19);
    case (sel)
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'h7F80_0000;
      3:       return 32'hFF80_0000;
      4:       return 32'h7FC0_0001;
      5:       return {1'($urandom), 8'h00, 23'($urandom) | 23'd1};
      6:       return {1'($urandom), 8'($urandom_range(1, 12)), 23'($urandom)};
      7:       return {1'($urandom), 8'($urandom_range(240, 254)), 23'($urandom)};
      default: return {1'($urandom), 8'($urandom_range(110, 144)), 23'($urandom)};
    endcase
  endfunction

  // Runs one operation with a single-cycle start pulse; operands are scrambled while busy.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                               output logic [31:0] result, output int latency, output logic doneAfter);
    @(negedge clk);
    bus.a      = a;
    bus.b      = b;
    bus.opcode = op;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.a      = $urandom;
    bus.b      = $urandom;
    bus.opcode = 2'($urandom);
    latency    = 1;
    while (!bus.done && latency < 12) begin
      @(negedge clk);
      latency++;
    end
    result = bus.s;
    @(negedge clk);
    doneAfter = bus.done;
  endtask

  logic [31:0] dirA  [7] = '{32'h4278_0000, 32'h4278_0000, 32'h4278_0000, 32'h4278_0000,
                             32'h4379_0000, 32'h7F80_0000, 32'h7F00_0000};
  logic [31:0] dirB  [7] = '{32'h4379_0000, 32'h4379_0000, 32'h4379_0000, 32'h4379_0000,
                             32'h4278_0000, 32'hFF80_0000, 32'h4000_0000};
  logic [1:0]  dirOp [7] = '{2'b10, 2'b00, 2'b01, 2'b11, 2'b11, 2'b00, 2'b10};
  logic [31:0] dirExp[7] = '{32'h4671_3800, 32'h439B_8000, 32'hC33B_0000, 32'h0000_0001,
                             32'h0000_0000, 32'h7FC0_0000, 32'h7F80_0000};

  initial begin
    logic [31:0] result;
    int          latency;
    logic        doneAfter;
    logic        sawDone;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  rop;
    int          gap;

    checkCount = 0;
    errorCount = 0;
    rst        = 1'b1;
    bus.a      = '0;
    bus.b      = '0;
    bus.opcode = '0;
    bus.start  = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_s", bus.s, 32'd0);
    checkOutput("reset_done", {31'd0, bus.done}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(dirA[i], dirB[i], dirOp[i], result, latency, doneAfter);
      checkOutput($sformatf("dir%0d_s", i), result, dirExp[i]);
      checkOutput($sformatf("dir%0d_latency", i), 32'(latency), 32'd5);
      checkOutput($sformatf("dir%0d_done_pulse", i), {31'd0, doneAfter}, 32'd0);
    end

    // Reset two cycles into an operation discards it.
    @(negedge clk);
    bus.a = 32'h4278_0000; bus.b = 32'h4379_0000; bus.opcode = OP_MUL; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_s", bus.s, 32'd0);
    checkOutput("midrst_done", {31'd0, bus.done}, 32'd0);
    sawDone = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) sawDone = 1'b1;
    end
    checkOutput("midrst_no_done", {31'd0, sawDone}, 32'd0);

    // Reset and start together: reset wins, nothing is accepted.
    @(negedge clk);
    rst = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    sawDone = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) sawDone = 1'b1;
    end
    checkOutput("rst_start_no_done", {31'd0, sawDone}, 32'd0);

    applyStimulus(32'h3F80_0000, 32'h3F80_0000, OP_ADD, result, latency, doneAfter);
    checkOutput("one_plus_one_s", result, 32'h4000_0000);
    checkOutput("one_plus_one_latency", 32'(latency), 32'd5);

    // Start held high: the next operation is accepted right after done.
    @(negedge clk);
    bus.a = 32'h4278_0000; bus.b = 32'h4379_0000; bus.opcode = OP_ADD; bus.start = 1'b1;
    latency = 0;
    do begin
      @(negedge clk);
      latency++;
    end while (!bus.done && latency < 12);
    checkOutput("b2b_first_s", bus.s, 32'h439B_8000);
    checkOutput("b2b_first_latency", 32'(latency), 32'd5);
    bus.a = 32'h3F80_0000; bus.b = 32'h4000_0000; bus.opcode = OP_MUL;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!bus.done && gap < 12);
    bus.start = 1'b0;
    checkOutput("b2b_second_s", bus.s, 32'h4000_0000);
    checkOutput("b2b_gap", 32'(gap), 32'd5);
    repeat (6) @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      ra  = randOperand();
      rb  = ($urandom_range(0, 3) == 0) ? (ra ^ {1'($urandom), 23'd0, 8'($urandom)}) : randOperand();
      rop = 2'($urandom);
      applyStimulus(ra, rb, rop, result, latency, doneAfter);
      checkOutput($sformatf("rand%0d_op%0d_%08h_%08h", i, rop, ra, rb), result, modelFp(ra, rb, rop));
      checkOutput($sformatf("rand%0d_latency", i), 32'(latency), 32'd5);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
